// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter: FSM encoding, timeout
// return pattern and wait-counter width.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  // Widest supported data bus; the arbiter slices the low DATA_WIDTH bits.
  localparam int MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_DATA = '1;

  // Wide enough for the largest read timeout (65535 cycles).
  localparam int CNT_W = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Simple strobe bus shared by requesters and the downstream resource.
// Handshake: wr/rd are single-cycle strobes with addr/wr_data valid alongside
// them and always accepted (no ready); a read completes with a one-cycle
// rd_data_valid pulse, rd_data being valid in that same cycle.
interface bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;

  modport master (
    output addr, wr, wr_data, rd,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  addr, wr, wr_data, rd,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/bus_arbiter_slot.sv
// One-deep pending request slot for a single requester port. Captures a
// request when empty or being released this cycle; otherwise drops it.
module bus_arb_slot #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  release_i,
  output logic                  full_o,
  output logic                  is_wr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  overflow_o
);

  logic                  full_q, full_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req;
  logic                  capture;

  assign req     = wr_i | rd_i;
  // A release in the same cycle frees the slot for the incoming request.
  assign capture = req & (~full_q | release_i);

  always_comb begin
    full_d  = full_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (capture) begin
      full_d  = 1'b1;
      is_wr_d = wr_i;
      addr_d  = addr_i;
      data_d  = wr_data_i;
    end else if (release_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Simultaneous wr+rd loses the read; a full, non-releasing slot loses all.
  assign overflow_o = (wr_i & rd_i) | (req & full_q & ~release_i);
  assign full_o     = full_q;
  assign is_wr_o    = is_wr_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one downstream strobe bus among NUM_PORTS
// requesters, with per-port pending slots, read timeout and sticky error flags.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  bus_if.slave                         up [NUM_PORTS],
  bus_if.master                        down,
  input  logic                         clr_err,
  output logic [NUM_PORTS-1:0]         overflow,
  output logic [NUM_PORTS-1:0]         timeout,
  output logic                         busy,
  output arb_state_t                   dbg_state_o,
  output logic [$clog2(NUM_PORTS)-1:0] dbg_rr_ptr_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(RD_TIMEOUT - 1);

  arb_state_t            state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  down_wr_q, down_wr_d;
  logic                  down_rd_q, down_rd_d;
  logic [ADDR_WIDTH-1:0] down_addr_q, down_addr_d;
  logic [DATA_WIDTH-1:0] down_data_q, down_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]  overflow_q, overflow_d;
  logic [NUM_PORTS-1:0]  timeout_q, timeout_d;

  logic [NUM_PORTS-1:0]  slot_full, slot_is_wr, slot_release, ovf_evt, to_evt;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slot_data [NUM_PORTS];
  logic                  pick_found;
  logic [PW-1:0]         pick_idx, cand;
  logic                  release_now;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    bus_arb_slot #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_i       (up[i].wr),
      .rd_i       (up[i].rd),
      .addr_i     (up[i].addr),
      .wr_data_i  (up[i].wr_data),
      .release_i  (slot_release[i]),
      .full_o     (slot_full[i]),
      .is_wr_o    (slot_is_wr[i]),
      .addr_o     (slot_addr[i]),
      .data_o     (slot_data[i]),
      .overflow_o (ovf_evt[i])
    );
    assign up[i].rd_data       = rd_data_q[i];
    assign up[i].rd_data_valid = rd_valid_q[i];
  end

  // First pending port at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!pick_found && slot_full[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = ISSUE;
      ISSUE:   state_d = down_wr_q ? IDLE : WAIT_RD;
      WAIT_RD: if (down.rd_data_valid || cnt_q == TO_LIMIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    down_wr_d   = 1'b0;
    down_rd_d   = 1'b0;
    down_addr_d = down_addr_q;
    down_data_d = down_data_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = '0;
    to_evt      = '0;
    release_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          down_addr_d = slot_addr[pick_idx];
          down_data_d = slot_data[pick_idx];
          down_wr_d   = slot_is_wr[pick_idx];
          down_rd_d   = ~slot_is_wr[pick_idx];
        end
      end
      ISSUE: begin
        cnt_d       = '0;
        release_now = down_wr_q;
      end
      WAIT_RD: begin
        if (down.rd_data_valid) begin
          rd_data_d[grant_q]  = down.rd_data;
          rd_valid_d[grant_q] = 1'b1;
          release_now         = 1'b1;
        end else if (cnt_q == TO_LIMIT) begin
          rd_data_d[grant_q]  = TIMEOUT_DATA[DATA_WIDTH-1:0];
          rd_valid_d[grant_q] = 1'b1;
          to_evt[grant_q]     = 1'b1;
          release_now         = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    slot_release = '0;
    if (release_now) begin
      slot_release[grant_q] = 1'b1;
      rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end
    // An error event in the clearing cycle still leaves its flag set.
    overflow_d = (clr_err ? '0 : overflow_q) | ovf_evt;
    timeout_d  = (clr_err ? '0 : timeout_q) | to_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      down_wr_q   <= 1'b0;
      down_rd_q   <= 1'b0;
      down_addr_q <= '0;
      down_data_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rd_data_q[i] <= '0;
      rd_valid_q  <= '0;
      overflow_q  <= '0;
      timeout_q   <= '0;
    end else begin
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      down_wr_q   <= down_wr_d;
      down_rd_q   <= down_rd_d;
      down_addr_q <= down_addr_d;
      down_data_q <= down_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign down.addr    = down_addr_q;
  assign down.wr_data = down_data_q;
  assign down.wr      = down_wr_q;
  assign down.rd      = down_rd_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != IDLE) || (|slot_full);
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two ports, 8-cycle read timeout, scoreboard
// of expected downstream strobes and upstream read returns.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clr_err = 1'b0;
  logic [NP-1:0]   overflow, timeout;
  logic            busy;
  arb_state_t      dbg_state;
  logic [0:0]      dbg_rr;

  logic            tb_wr    [NP];
  logic            tb_rd    [NP];
  logic [AW-1:0]   tb_addr  [NP];
  logic [DW-1:0]   tb_wdata [NP];
  logic [DW-1:0]   up_rdata [NP];
  logic            up_rvalid[NP];

  logic            resp_valid = 1'b0;
  logic [DW-1:0]   resp_data = '0;
  logic            man_valid = 1'b0;
  logic [DW-1:0]   man_data = '0;
  logic [DW-1:0]   resp_q[$];

  logic [65:0]     exp_down_q[$];
  logic [32:0]     exp_ret_q[$];
  logic [65:0]     mon_obs, mon_exp;
  logic [32:0]     ret_obs, ret_exp;
  int              checks = 0;
  int              errors = 0;

  bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up_if [NP] ();
  bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();

  for (genvar i = 0; i < NP; i++) begin : g_up
    assign up_if[i].wr      = tb_wr[i];
    assign up_if[i].rd      = tb_rd[i];
    assign up_if[i].addr    = tb_addr[i];
    assign up_if[i].wr_data = tb_wdata[i];
    assign up_rdata[i]      = up_if[i].rd_data;
    assign up_rvalid[i]     = up_if[i].rd_data_valid;
  end

  assign dn_if.rd_data_valid = resp_valid | man_valid;
  assign dn_if.rd_data       = man_valid ? man_data : resp_data;

  bus_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .up           (up_if),
    .down         (dn_if),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .timeout      (timeout),
    .busy         (busy),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream model: answers a read three cycles after its strobe, if armed.
  always begin
    @(posedge clk); #1;
    if (dn_if.rd === 1'b1 && resp_q.size() > 0) begin
      repeat (3) begin @(posedge clk); #1; end
      resp_data  = resp_q.pop_front();
      resp_valid = 1'b1;
      @(posedge clk); #1;
      resp_valid = 1'b0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (dn_if.wr === 1'b1 || dn_if.rd === 1'b1) begin
        mon_obs = {dn_if.wr, dn_if.rd, dn_if.addr, (dn_if.wr ? dn_if.wr_data : 32'h0)};
        checks++;
        if (exp_down_q.size() == 0) begin
          errors++;
          $error("FAIL down_unexpected observed=%h expected=none", mon_obs);
        end else begin
          mon_exp = exp_down_q.pop_front();
          assert (mon_obs === mon_exp) else begin
            errors++;
            $error("FAIL down_strobe observed=%h expected=%h", mon_obs, mon_exp);
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (up_rvalid[p] !== 1'b0) begin
          ret_obs = {1'(p), up_rdata[p]};
          checks++;
          if (exp_ret_q.size() == 0) begin
            errors++;
            $error("FAIL ret_unexpected observed=%h expected=none", ret_obs);
          end else begin
            ret_exp = exp_ret_q.pop_front();
            assert (ret_obs === ret_exp) else begin
              errors++;
              $error("FAIL rd_return observed=%h expected=%h", ret_obs, ret_exp);
            end
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) begin
      tb_wr[p] = 1'b0; tb_rd[p] = 1'b0; tb_addr[p] = '0; tb_wdata[p] = '0;
    end
  endtask

  task automatic set_req(input int p, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_wr[p] = w; tb_rd[p] = r; tb_addr[p] = a; tb_wdata[p] = d;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_down_q.size() != 0 || exp_ret_q.size() != 0) && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk(tag, 66'(exp_down_q.size() + exp_ret_q.size()), 66'(0));
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk(tag, 66'(busy), 66'(0));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},  66'(busy), 66'(0));
    chk({tag, "_state"}, 66'(dbg_state), 66'(IDLE));
    chk({tag, "_rr"},    66'(dbg_rr), 66'(0));
    chk({tag, "_flags"}, 66'({overflow, timeout}), 66'(0));
    chk({tag, "_down"},  {dn_if.wr, dn_if.rd, dn_if.addr, dn_if.wr_data}, 66'(0));
    chk({tag, "_up"},    66'({up_rvalid[0], up_rvalid[1], up_rdata[0]}), 66'(0));
    chk({tag, "_up1"},   66'(up_rdata[1]), 66'(0));
  endtask

  initial begin
    clear_reqs();
    reset_n = 1'b0;
    tick(3);
    chk_reset_values("reset");
    reset_n = 1'b1;
    tick(1);

    // Single write from port 0: idle gap, one strobe, then bus idle.
    exp_down_q.push_back({1'b1, 1'b0, 32'h10, 32'hA5A5A5A5});
    set_req(0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5);
    tick(1);
    clear_reqs();
    chk("wr_gap", 66'(dn_if.wr), 66'(0));
    chk("wr_busy", 66'(busy), 66'(1));
    tick(1);
    chk("wr_strobe", {dn_if.wr, dn_if.rd, dn_if.addr, dn_if.wr_data},
        {1'b1, 1'b0, 32'h10, 32'hA5A5A5A5});
    tick(1);
    chk("wr_once", 66'(dn_if.wr), 66'(0));
    chk("wr_busy_fall", 66'(busy), 66'(0));
    chk("rr_after_p0", 66'(dbg_rr), 66'(1));

    // Simultaneous reads from both ports, round robin from pointer 0.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    resp_q.push_back(32'h11);
    resp_q.push_back(32'h22);
    exp_down_q.push_back({1'b0, 1'b1, 32'hA0, 32'h0});
    exp_down_q.push_back({1'b0, 1'b1, 32'hA4, 32'h0});
    exp_ret_q.push_back({1'b0, 32'h11});
    exp_ret_q.push_back({1'b1, 32'h22});
    set_req(0, 1'b0, 1'b1, 32'hA0, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'hA4, 32'h0);
    tick(1);
    clear_reqs();
    wait_drain("rr_reads", 60);
    tick(2);
    chk("rr_ptr_wrap", 66'(dbg_rr), 66'(0));
    chk("rr_idle", 66'(busy), 66'(0));
    chk("hold_p0", 66'(up_rdata[0]), 66'(32'h11));
    chk("hold_p1", 66'(up_rdata[1]), 66'(32'h22));
    chk("valid_low", 66'({up_rvalid[0], up_rvalid[1]}), 66'(0));

    // Read from port 1 with no downstream answer.
    exp_down_q.push_back({1'b0, 1'b1, 32'hB0, 32'h0});
    exp_ret_q.push_back({1'b1, 32'hFFFFFFFF});
    set_req(1, 1'b0, 1'b1, 32'hB0, 32'h0);
    tick(1);
    clear_reqs();
    tick(6);
    chk("to_still_waiting", 66'(dbg_state), 66'(WAIT_RD));
    chk("to_not_yet", 66'(timeout), 66'(0));
    wait_drain("to_return", 40);
    tick(1);
    chk("to_flag", 66'(timeout), 66'(2'b10));
    chk("to_data_hold", 66'(up_rdata[1]), 66'(32'hFFFFFFFF));
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("to_clear", 66'(timeout), 66'(0));

    // Port 0 write burst while port 1 holds the bus in WAIT_RD.
    exp_down_q.push_back({1'b0, 1'b1, 32'hC0, 32'h0});
    exp_ret_q.push_back({1'b1, 32'hFFFFFFFF});
    set_req(1, 1'b0, 1'b1, 32'hC0, 32'h0);
    tick(1);
    clear_reqs();
    tick(2);
    exp_down_q.push_back({1'b1, 1'b0, 32'h40, 32'h11111111});
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h11111111);
    tick(1);
    set_req(0, 1'b1, 1'b0, 32'h44, 32'h22222222);
    tick(1);
    set_req(0, 1'b1, 1'b0, 32'h48, 32'h33333333);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    clear_reqs();
    chk("ovf_set_wins", 66'(overflow), 66'(2'b01));
    chk("ovf_held", 66'(dbg_state), 66'(WAIT_RD));
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("ovf_clear", 66'(overflow), 66'(0));
    wait_drain("burst_drain", 40);
    wait_idle("burst_idle", 10);
    chk("burst_to_flag", 66'(timeout), 66'(2'b10));

    // New request in the cycle the slot is released is captured.
    exp_down_q.push_back({1'b1, 1'b0, 32'h50, 32'hAAAA0001});
    set_req(0, 1'b1, 1'b0, 32'h50, 32'hAAAA0001);
    tick(1);
    clear_reqs();
    tick(1);
    chk("rel_in_issue", 66'(dbg_state), 66'(ISSUE));
    exp_down_q.push_back({1'b1, 1'b0, 32'h54, 32'hAAAA0002});
    set_req(0, 1'b1, 1'b0, 32'h54, 32'hAAAA0002);
    tick(1);
    clear_reqs();
    chk("rel_no_ovf", 66'(overflow), 66'(0));
    wait_drain("rel_drain", 20);
    wait_idle("rel_idle", 10);

    // Write and read together: the write wins, the read is flagged.
    exp_down_q.push_back({1'b1, 1'b0, 32'hD0, 32'h00000055});
    set_req(1, 1'b1, 1'b1, 32'hD0, 32'h00000055);
    tick(1);
    clear_reqs();
    chk("wrrd_ovf", 66'(overflow), 66'(2'b10));
    wait_drain("wrrd_drain", 20);
    wait_idle("wrrd_idle", 10);

    // Reset during WAIT_RD abandons the read; late valid is ignored.
    exp_down_q.push_back({1'b0, 1'b1, 32'h70, 32'h0});
    set_req(0, 1'b0, 1'b1, 32'h70, 32'h0);
    tick(1);
    clear_reqs();
    tick(3);
    chk("rst_mid_state", 66'(dbg_state), 66'(WAIT_RD));
    reset_n = 1'b0;
    #1;
    chk("rst_async_busy", 66'(busy), 66'(0));
    tick(1);
    reset_n = 1'b1;
    man_data  = 32'hDEADBEEF;
    man_valid = 1'b1;
    tick(1);
    man_valid = 1'b0;
    tick(3);
    chk_reset_values("post_rst");

    chk("sb_empty", 66'(exp_down_q.size() + exp_ret_q.size()), 66'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
